// File: rtl/ir_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : ir_scan_ctrl_if
// Brief    : Conversion handshake between the IR scan controller and A2D_intf.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ir_scan_ctrl_if #(
    parameter int NUM_CH = 8,
    parameter int RES_W  = 12
);
    localparam int CH_W = $clog2(NUM_CH);

    logic             strt_cnv;
    logic [CH_W-1:0]  chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

`default_nettype wire

// File: rtl/ir_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ir_scan_ctrl
// Brief    : IR line-sensor scan controller: settle, convert NUM_CH channels with
//            optional oversampling, publish results, peak channel and line flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ir_scan_ctrl #(
    parameter int              NUM_CH     = 8,
    parameter int              RES_W      = 12,
    parameter int              OS_LOG2    = 0,
    parameter int              ROUND_CYC  = 262144,
    parameter int              SETTLE_CYC = 4096,
    parameter int              TMO_CYC    = 1024,
    parameter logic [RES_W-1:0] LINE_THRES = 'h040
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scan_en,
    ir_scan_ctrl_if.master              a2d,
    output logic                        IR_en,
    output logic                        IR_vld,
    output logic [NUM_CH*RES_W-1:0]     ir_bus,
    output logic [$clog2(NUM_CH)-1:0]   peak_ch,
    output logic                        line_present,
    output logic                        scan_err
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = RES_W + OS_LOG2;
    localparam int SC_W  = (OS_LOG2 > 0) ? OS_LOG2 : 1;
    localparam int RT_W  = $clog2(ROUND_CYC);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int TM_W  = $clog2(TMO_CYC + 1);

    localparam logic [SC_W-1:0] c_SC_LAST  = SC_W'((1 << OS_LOG2) - 1);
    localparam logic [CH_W-1:0] c_LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [RT_W-1:0] c_RT_LAST  = RT_W'(ROUND_CYC - 1);
    localparam logic [ST_W-1:0] c_ST_LAST  = ST_W'(SETTLE_CYC - 1);
    localparam logic [TM_W-1:0] c_TMO_LAST = TM_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CONV   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [RT_W-1:0]    r_rnd_cnt;
    logic [ST_W-1:0]    r_settle_cnt;
    logic [TM_W-1:0]    r_wait_cnt;
    logic [SC_W-1:0]    r_samp_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [RES_W-1:0]   r_peak_val;
    logic [CH_W-1:0]    r_peak_idx;
    logic               r_strt_cnv;
    logic [CH_W-1:0]    r_chnnl;

    logic               w_rnd_tick;
    logic [ACC_W-1:0]   w_sum;
    logic [RES_W-1:0]   w_avg;
    logic               w_new_peak;
    logic [RES_W-1:0]   w_peak_val_n;
    logic [CH_W-1:0]    w_peak_idx_n;
    logic               w_os_last;

    assign a2d.strt_cnv = r_strt_cnv;
    assign a2d.chnnl    = r_chnnl;

    assign w_rnd_tick   = (r_rnd_cnt == c_RT_LAST);
    assign w_sum        = r_acc + ACC_W'(a2d.res);
    assign w_avg        = RES_W'(w_sum >> OS_LOG2);
    // Strict compare: on a tie the earlier (lower) channel keeps the peak.
    assign w_new_peak   = (w_avg > r_peak_val);
    assign w_peak_val_n = w_new_peak ? w_avg   : r_peak_val;
    assign w_peak_idx_n = w_new_peak ? r_chnnl : r_peak_idx;
    assign w_os_last    = (r_samp_cnt == c_SC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnd_cnt <= '0;
        end else if (w_rnd_tick) begin
            r_rnd_cnt <= '0;
        end else begin
            r_rnd_cnt <= r_rnd_cnt + RT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_wait_cnt   <= '0;
            r_samp_cnt   <= '0;
            r_acc        <= '0;
            r_peak_val   <= '0;
            r_peak_idx   <= '0;
            r_strt_cnv   <= 1'b0;
            r_chnnl      <= '0;
            IR_en        <= 1'b0;
            IR_vld       <= 1'b0;
            ir_bus       <= '0;
            peak_ch      <= '0;
            line_present <= 1'b0;
            scan_err     <= 1'b0;
        end else begin
            r_strt_cnv <= 1'b0;
            IR_vld     <= 1'b0;
            scan_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Round-local state is cleared here so an aborted round leaves nothing behind.
                    if (w_rnd_tick && scan_en) begin
                        r_state      <= S_SETTLE;
                        IR_en        <= 1'b1;
                        r_chnnl      <= '0;
                        r_settle_cnt <= '0;
                        r_acc        <= '0;
                        r_samp_cnt   <= '0;
                        r_peak_val   <= '0;
                        r_peak_idx   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == c_ST_LAST) begin
                        r_state    <= S_CONV;
                        r_strt_cnv <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + ST_W'(1);
                    end
                end
                S_CONV: begin
                    if (a2d.cnv_cmplt) begin
                        r_wait_cnt <= '0;
                        if (!w_os_last) begin
                            r_acc      <= w_sum;
                            r_samp_cnt <= r_samp_cnt + SC_W'(1);
                            r_strt_cnv <= 1'b1;
                        end else begin
                            r_acc      <= '0;
                            r_samp_cnt <= '0;
                            ir_bus[r_chnnl*RES_W +: RES_W] <= w_avg;
                            r_peak_val <= w_peak_val_n;
                            r_peak_idx <= w_peak_idx_n;
                            if (r_chnnl == c_LAST_CH) begin
                                // Publish on the final sample so IR_vld lands one cycle after it.
                                r_state      <= S_DONE;
                                IR_vld       <= 1'b1;
                                peak_ch      <= w_peak_idx_n;
                                line_present <= (w_peak_val_n > LINE_THRES);
                                IR_en        <= 1'b0;
                            end else begin
                                r_chnnl    <= r_chnnl + CH_W'(1);
                                r_strt_cnv <= 1'b1;
                            end
                        end
                    end else if (r_wait_cnt == c_TMO_LAST) begin
                        scan_err <= 1'b1;
                        IR_en    <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TM_W'(1);
                    end
                end
                S_DONE: begin
                    r_peak_val <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ir_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ir_scan_ctrl
// Brief    : Randomised A2D responder and round-level reference model for ir_scan_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ir_scan_ctrl;
    localparam int          NUM_CH     = 8;
    localparam int          RES_W      = 12;
    localparam int          OS_LOG2    = 2;
    localparam int          NS         = 1 << OS_LOG2;
    localparam int          NCONV      = NUM_CH * NS;
    localparam int          ROUND_CYC  = 1024;
    localparam int          SETTLE_CYC = 16;
    localparam int          TMO_CYC    = 40;
    localparam logic [11:0] LINE_THRES = 12'h040;
    localparam int          M_RAMP = 0, M_FLAT = 1, M_SEQ3 = 2, M_RAND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scan_en = 1'b0;
    logic IR_en, IR_vld, line_present, scan_err;
    logic [NUM_CH*RES_W-1:0] ir_bus;
    logic [2:0] peak_ch;

    ir_scan_ctrl_if #(.NUM_CH(NUM_CH), .RES_W(RES_W)) a2d ();

    ir_scan_ctrl #(
        .NUM_CH(NUM_CH), .RES_W(RES_W), .OS_LOG2(OS_LOG2), .ROUND_CYC(ROUND_CYC),
        .SETTLE_CYC(SETTLE_CYC), .TMO_CYC(TMO_CYC), .LINE_THRES(LINE_THRES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .a2d(a2d),
        .IR_en(IR_en), .IR_vld(IR_vld), .ir_bus(ir_bus), .peak_ch(peak_ch),
        .line_present(line_present), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int strt_cnt = 0, vld_cnt = 0, err_cnt = 0, rise_cnt = 0;
    int rise_cyc = 0, first_strt_cyc = 0, last_strt_cyc = 0, vld_cyc = 0, err_cyc = 0;
    bit prev_en = 1'b0, need_first = 1'b0;
    always @(negedge clk) begin
        if (IR_en && !prev_en) begin
            rise_cnt++; rise_cyc = cyc; need_first = 1'b1;
        end
        prev_en = IR_en;
        if (a2d.strt_cnv) begin
            strt_cnt++; last_strt_cyc = cyc;
            if (need_first) begin first_strt_cyc = cyc; need_first = 1'b0; end
        end
        if (IR_vld)   begin vld_cnt++; vld_cyc = cyc; end
        if (scan_err) begin err_cnt++; err_cyc = cyc; end
    end

    // A2D responder: answers each request after 0..3 cycles, or never for the withheld channel.
    int g_mode = M_RAND;
    int wh_ch = -1;
    int n_samp = 0, dly = 0, chan_err = 0, gap_err = 0, last_cmplt_cyc = 0;
    bit pend = 1'b0, had_cmplt = 1'b0, prev_en_r = 1'b0;
    logic [11:0] vals [NCONV];

    function automatic logic [11:0] gen(input int mode, input int ch, input int s);
        case (mode)
            M_RAMP:  return 12'h100 + 12'(ch);
            M_FLAT:  return 12'h040;
            M_SEQ3:  return (ch == 3) ? 12'h010 + 12'(s) : 12'($urandom_range(0, 255));
            default: return ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        logic [11:0] v;
        a2d.cnv_cmplt = 1'b0;
        a2d.res = '0;
        forever begin
            @(negedge clk);
            a2d.cnv_cmplt = 1'b0;
            if (!rst_n) pend = 1'b0;
            if (IR_en && !prev_en_r) begin n_samp = 0; had_cmplt = 1'b0; end
            prev_en_r = IR_en;
            if (a2d.strt_cnv && rst_n) begin
                if (int'(a2d.chnnl) != n_samp / NS) chan_err++;
                if (had_cmplt && (cyc - last_cmplt_cyc != 1)) gap_err++;
                pend = 1'b1;
                dly = $urandom_range(0, 3);
            end
            if (pend) begin
                if (n_samp / NS == wh_ch) begin
                    pend = 1'b0;
                end else if (dly == 0) begin
                    v = gen(g_mode, n_samp / NS, n_samp % NS);
                    if (n_samp < NCONV) vals[n_samp] = v;
                    a2d.res = v;
                    a2d.cnv_cmplt = 1'b1;
                    n_samp++;
                    pend = 1'b0;
                    had_cmplt = 1'b1;
                    last_cmplt_cyc = cyc;
                end else begin
                    dly--;
                end
            end
        end
    end

    int n_checks = 0, n_errors = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: what the published outputs should currently hold.
    logic [11:0] exp_bus [NUM_CH];
    int exp_peak = 0;
    bit exp_line = 1'b0;

    function automatic logic [NUM_CH*RES_W-1:0] pack_exp();
        logic [NUM_CH*RES_W-1:0] e;
        for (int k = 0; k < NUM_CH; k++) e[k*RES_W +: RES_W] = exp_bus[k];
        return e;
    endfunction

    task automatic run_round(input int mode, input int wh, input bit drop);
        int  b_strt, b_vld, b_err, b_rise, m, sum;
        bit  ok;
        g_mode = mode;
        wh_ch  = wh;
        b_strt = strt_cnt; b_vld = vld_cnt; b_err = err_cnt; b_rise = rise_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2*ROUND_CYC && !ok; i++) begin
            @(negedge clk); #1;
            ok = (rise_cnt > b_rise);
        end
        chk("round_start", ok, 1);
        if (!ok) return;
        if (drop) begin
            ok = 1'b0;
            for (int i = 0; i < 2*ROUND_CYC && !ok; i++) begin
                @(negedge clk); #1;
                ok = (strt_cnt > b_strt);
            end
            scan_en = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 2*ROUND_CYC && !ok; i++) begin
            @(negedge clk); #1;
            ok = (vld_cnt > b_vld) || (err_cnt > b_err);
        end
        chk("round_end", ok, 1);
        if (!ok) return;
        chk("settle_lat", first_strt_cyc - rise_cyc, SETTLE_CYC);
        chk("ir_en_off", IR_en, 0);
        chk("chnnl_seq", chan_err, 0);
        chk("strt_gap", gap_err, 0);
        if (wh < 0) begin
            chk("vld_cnt", vld_cnt - b_vld, 1);
            chk("err_cnt", err_cnt - b_err, 0);
            chk("strt_cnt", strt_cnt - b_strt, NCONV);
            chk("vld_lat", vld_cyc - last_cmplt_cyc, 1);
            for (int k = 0; k < NUM_CH; k++) begin
                sum = 0;
                for (int s = 0; s < NS; s++) sum += int'(vals[k*NS + s]);
                exp_bus[k] = 12'(sum / NS);
            end
            m = 0;
            for (int k = 0; k < NUM_CH; k++) if (int'(exp_bus[k]) > m) m = int'(exp_bus[k]);
            exp_peak = -1;
            for (int k = 0; k < NUM_CH; k++) if (exp_peak < 0 && int'(exp_bus[k]) == m) exp_peak = k;
            exp_line = (m > int'(LINE_THRES));
        end else begin
            chk("vld_cnt_tmo", vld_cnt - b_vld, 0);
            chk("err_cnt_tmo", err_cnt - b_err, 1);
            chk("tmo_lat", err_cyc - last_strt_cyc, TMO_CYC);
            chk("strt_cnt_tmo", strt_cnt - b_strt, wh*NS + 1);
            for (int k = 0; k < wh; k++) begin
                sum = 0;
                for (int s = 0; s < NS; s++) sum += int'(vals[k*NS + s]);
                exp_bus[k] = 12'(sum / NS);
            end
        end
        chk("ir_bus", ir_bus, pack_exp());
        chk("peak_ch", peak_ch, exp_peak);
        chk("line_present", line_present, exp_line);
        repeat (2) @(negedge clk);
        #1;
        chk("vld_single", vld_cnt - b_vld, (wh < 0) ? 1 : 0);
    endtask

    initial begin
        int  b_rise, b_strt, rel;
        bit  ok;
        for (int k = 0; k < NUM_CH; k++) exp_bus[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ir_bus", ir_bus, 0);
        chk("rst_ctl", {IR_en, IR_vld, a2d.strt_cnv, a2d.chnnl, peak_ch, line_present, scan_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scanning disabled from reset: no rounds at all.
        b_rise = rise_cnt; b_strt = strt_cnt;
        repeat (ROUND_CYC + 20) @(negedge clk);
        #1;
        chk("idle_no_en", rise_cnt - b_rise, 0);
        chk("idle_no_strt", strt_cnt - b_strt, 0);

        scan_en = 1'b1;
        run_round(M_RAMP, -1, 1'b0);
        chk("ramp_ch7", ir_bus[7*RES_W +: RES_W], 12'h107);
        chk("ramp_peak", peak_ch, 7);
        chk("ramp_line", line_present, 1);
        run_round(M_FLAT, -1, 1'b0);
        chk("flat_peak", peak_ch, 0);
        chk("flat_line", line_present, 0);
        run_round(M_SEQ3, -1, 1'b0);
        chk("os_ch3", ir_bus[3*RES_W +: RES_W], 12'h011);
        repeat (3) run_round(M_RAND, -1, 1'b0);
        run_round(M_RAND, 5, 1'b0);
        run_round(M_RAND, -1, 1'b0);

        // Drop scan_en mid-round: this round finishes, none follows.
        run_round(M_RAND, -1, 1'b1);
        b_rise = rise_cnt; b_strt = strt_cnt;
        repeat (2*ROUND_CYC) @(negedge clk);
        #1;
        chk("stop_no_en", rise_cnt - b_rise, 0);
        chk("stop_no_strt", strt_cnt - b_strt, 0);

        // Asynchronous reset in the middle of conversions.
        scan_en = 1'b1;
        g_mode = M_RAND; wh_ch = -1;
        b_strt = strt_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2*ROUND_CYC && !ok; i++) begin
            @(negedge clk); #1;
            ok = (strt_cnt - b_strt >= 3);
        end
        chk("pre_rst_conv", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ir_bus", ir_bus, 0);
        chk("arst_ctl", {IR_en, IR_vld, a2d.strt_cnv, a2d.chnnl, peak_ch, line_present, scan_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < NUM_CH; k++) exp_bus[k] = '0;
        exp_peak = 0;
        exp_line = 1'b0;
        run_round(M_RAND, -1, 1'b0);
        chk("rst_first_tick", rise_cyc - rel, ROUND_CYC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
